product_accumulator: RTL and testbench

Downstream stage of `radix4_mult`. Consumes the signed 64-bit product stream (`C` qualified by `valid_out`) and accumulates products into groups (dot products) delimited by a `last` flag. Each completed group pushes its sum, product count and overflow flag into a small result FIFO. The FIFO is drained through a valid/ready handshake. The multiplier cannot be stalled, so this block never back-pressures its input; it records dropped results instead.

---
 rtl/product_accumulator.sv | 148 ++++++++++++++
 tb/tb_product_accumulator.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: accumulates a signed 64-bit product stream into
// groups delimited by in_last, saturating at the ACC_W signed range, and
// queues {sum, count, ovf} per completed group in a small result FIFO.
// The input is never stalled; results that find the FIFO full are dropped
// and flagged on the sticky err_drop output.
module product_accumulator #(
  parameter int unsigned ACC_W = 72,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic signed [63:0]      in_prod,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_ovf,
  output logic                    err_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic signed [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  // group state
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    err_q, err_d;

  // FIFO pointers carry one wrap bit to tell full from empty
  logic [AW:0]             wr_q, wr_d, rd_q, rd_d;
  logic signed [ACC_W-1:0] sum_mem_q [DEPTH];
  logic [CNT_W-1:0]        cnt_mem_q [DEPTH];
  logic                    ovf_mem_q [DEPTH];

  // datapath for the current product
  logic signed [ACC_W-1:0] base_acc;
  logic [CNT_W-1:0]        base_cnt;
  logic                    base_ovf;
  logic signed [ACC_W:0]   wide;
  logic                    add_ovf;
  logic signed [ACC_W-1:0] res_sum;
  logic [CNT_W-1:0]        res_cnt;
  logic                    res_ovf;

  logic empty, full, pop, push_req, push, drop;

  // Saturating add; clr makes the incoming product start a fresh group
  always_comb begin
    base_acc = clr ? '0 : acc_q;
    base_cnt = clr ? '0 : cnt_q;
    base_ovf = clr ? 1'b0 : ovf_q;
    wide     = {base_acc[ACC_W-1], base_acc}
             + {{(ACC_W + 1 - 64){in_prod[63]}}, in_prod};
    add_ovf  = wide[ACC_W] ^ wide[ACC_W-1];
    if (add_ovf) begin
      res_sum = wide[ACC_W] ? SMIN : SMAX;
    end else begin
      res_sum = wide[ACC_W-1:0];
    end
    res_cnt = (&base_cnt) ? base_cnt : base_cnt + CNT_W'(1);
    res_ovf = base_ovf | add_ovf;
  end

  // FIFO control: a pop in the same cycle frees room for a push into a full FIFO
  always_comb begin
    empty    = (wr_q == rd_q);
    full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop      = !empty && out_ready;
    push_req = in_valid && in_last;
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    wr_d     = push ? wr_q + (AW + 1)'(1) : wr_q;
    rd_d     = pop ? rd_q + (AW + 1)'(1) : rd_q;
    err_d    = err_q | drop;
  end

  // Group next-state: a completed group always restarts, pushed or dropped
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (in_valid) begin
      if (in_last) begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = res_sum;
        cnt_d = res_cnt;
        ovf_d = res_ovf;
      end
    end else if (clr) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

  // FIFO storage, cleared on reset so idle outputs read as zero
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sum_mem_q[i] <= '0;
        cnt_mem_q[i] <= '0;
        ovf_mem_q[i] <= 1'b0;
      end
    end else if (push) begin
      sum_mem_q[wr_q[AW-1:0]] <= res_sum;
      cnt_mem_q[wr_q[AW-1:0]] <= res_cnt;
      ovf_mem_q[wr_q[AW-1:0]] <= res_ovf;
    end
  end

  // Outputs come straight from the FIFO head
  always_comb begin
    out_valid = !empty;
    out_sum   = sum_mem_q[rd_q[AW-1:0]];
    out_count = cnt_mem_q[rd_q[AW-1:0]];
    out_ovf   = ovf_mem_q[rd_q[AW-1:0]];
    err_drop  = err_q;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: a default build (ACC_W=72,
// DEPTH=4) and a narrow build (ACC_W=64, CNT_W=2) for saturation cases.
module tb_product_accumulator;

  typedef struct {
    logic signed [71:0] sum;
    logic [15:0]        cnt;
    logic               ovf;
  } exp_t;

  logic CLK = 1'b0;
  logic rst_n;

  // default build
  logic               clr, in_valid, in_last, out_ready;
  logic signed [63:0] in_prod;
  logic               out_valid, out_ovf, err_drop;
  logic signed [71:0] out_sum;
  logic [15:0]        out_count;

  // narrow build
  logic               clr64, v64, l64, ready64;
  logic signed [63:0] p64;
  logic               valid64, ovf64, drop64;
  logic signed [63:0] sum64;
  logic [1:0]         count64;

  exp_t exp_q[$];
  exp_t exp64_q[$];
  exp_t mon_e, mon64_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 CLK = ~CLK;

  product_accumulator #(.ACC_W(72), .CNT_W(16), .DEPTH(4)) dut (
    .CLK(CLK), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .out_ovf(out_ovf), .err_drop(err_drop)
  );

  product_accumulator #(.ACC_W(64), .CNT_W(2), .DEPTH(4)) dut64 (
    .CLK(CLK), .rst_n(rst_n), .clr(clr64), .in_valid(v64),
    .in_prod(p64), .in_last(l64), .out_valid(valid64),
    .out_ready(ready64), .out_sum(sum64), .out_count(count64),
    .out_ovf(ovf64), .err_drop(drop64)
  );

  // monitor for the default build: compare each handshaken result
  always @(negedge CLK) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result: got sum=%0d count=%0d ovf=%0b, required no result",
                 out_sum, out_count, out_ovf);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_sum !== mon_e.sum || out_count !== mon_e.cnt || out_ovf !== mon_e.ovf) begin
          n_bad++;
          $display("FAIL result: got sum=%0d count=%0d ovf=%0b, required sum=%0d count=%0d ovf=%0b",
                   out_sum, out_count, out_ovf, mon_e.sum, mon_e.cnt, mon_e.ovf);
        end
      end
    end
  end

  // monitor for the narrow build
  always @(negedge CLK) begin
    if (rst_n && valid64 && ready64) begin
      n_cmp++;
      if (exp64_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result64: got sum=%0h count=%0d ovf=%0b, required no result",
                 sum64, count64, ovf64);
      end else begin
        mon64_e = exp64_q.pop_front();
        if (sum64 !== mon64_e.sum[63:0] || count64 !== mon64_e.cnt[1:0] || ovf64 !== mon64_e.ovf) begin
          n_bad++;
          $display("FAIL result64: got sum=%0h count=%0d ovf=%0b, required sum=%0h count=%0d ovf=%0b",
                   sum64, count64, ovf64, mon64_e.sum[63:0], mon64_e.cnt[1:0], mon64_e.ovf);
        end
      end
    end
  end

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic expect72(input logic signed [71:0] s, input logic [15:0] c, input logic o);
    exp_t e;
    e.sum = s; e.cnt = c; e.ovf = o;
    exp_q.push_back(e);
  endtask

  task automatic expect64(input logic signed [63:0] s, input logic [1:0] c, input logic o);
    exp_t e;
    e.sum = {{8{s[63]}}, s}; e.cnt = {14'd0, c}; e.ovf = o;
    exp64_q.push_back(e);
  endtask

  // one product on the default build; returns 1 time unit after the edge
  task automatic send(input logic signed [63:0] p, input logic last, input logic c);
    in_valid = 1'b1; in_prod = p; in_last = last; clr = c;
    @(posedge CLK); #1;
    in_valid = 1'b0; in_last = 1'b0; clr = 1'b0; in_prod = '0;
  endtask

  task automatic send64(input logic signed [63:0] p, input logic last);
    v64 = 1'b1; p64 = p; l64 = last;
    @(posedge CLK); #1;
    v64 = 1'b0; l64 = 1'b0; p64 = '0;
  endtask

  // bounded wait for both scoreboards to empty
  task automatic drain(input string name);
    for (int i = 0; i < 60 && (exp_q.size() != 0 || exp64_q.size() != 0); i++) @(posedge CLK);
    #1;
    check({name, "_pending"}, 72'(exp_q.size() + exp64_q.size()), 72'd0);
  endtask

  initial begin
    logic signed [71:0] snap;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_prod = '0; out_ready = 1'b0;
    clr64 = 1'b0; v64 = 1'b0; l64 = 1'b0; p64 = '0; ready64 = 1'b1;
    #12;
    check("rst_out_valid", 72'(out_valid), 72'd0);
    check("rst_out_sum", out_sum, 72'd0);
    check("rst_out_count", 72'(out_count), 72'd0);
    check("rst_out_ovf", 72'(out_ovf), 72'd0);
    check("rst_err_drop", 72'(err_drop), 72'd0);
    @(negedge CLK); rst_n = 1'b1;
    @(posedge CLK); #1;

    // group of four 100*100 products
    out_ready = 1'b1;
    send(10000, 0, 0); send(10000, 0, 0); send(10000, 0, 0);
    check("no_early_valid", 72'(out_valid), 72'd0);
    expect72(40000, 4, 0);
    send(10000, 1, 0);
    check("latency_valid", 72'(out_valid), 72'd1);
    check("latency_sum", out_sum, 72'd40000);
    drain("group4");

    // signed mix, then back-to-back single-product groups at full rate
    expect72(-150, 3, 0); expect72(-7, 1, 0);
    send(100, 0, 0); send(-300, 0, 0); send(50, 1, 0); send(-7, 1, 0);
    for (int i = 0; i < 8; i++) begin
      expect72(72'(i * 37 - 100), 1, 0);
      send(64'(i * 37 - 100), 1, 0);
    end
    drain("signed_mix");

    // wide build absorbs 2*(2^63-1)+1 without saturating
    expect72(72'sh00_FFFF_FFFF_FFFF_FFFF, 3, 0);
    send(64'sh7FFF_FFFF_FFFF_FFFF, 0, 0); send(64'sh7FFF_FFFF_FFFF_FFFF, 0, 0); send(1, 1, 0);
    drain("wide_no_sat");

    // fill the FIFO, overflow it by one, check stability, drain exactly DEPTH
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expect72(72'(i), 1, 0);
      send(64'(i), 1, 0);
    end
    check("no_drop_yet", 72'(err_drop), 72'd0);
    send(5, 1, 0);
    check("err_drop_set", 72'(err_drop), 72'd1);
    @(negedge CLK);
    snap = out_sum;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("full_stable_valid", 72'(out_valid), 72'd1);
      check("full_stable_sum", out_sum, snap);
      check("full_head_sum", out_sum, 72'd1);
    end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    drain("full_drain");

    // push into a full FIFO in the same cycle as a pop is accepted
    out_ready = 1'b0;
    for (int i = 11; i <= 14; i++) begin
      expect72(72'(i), 1, 0);
      send(64'(i), 1, 0);
    end
    expect72(15, 1, 0);
    out_ready = 1'b1;
    send(15, 1, 0);
    drain("pop_push_full");

    // clr alone and clr together with a product
    expect72(9, 1, 0); expect72(4, 1, 0);
    send(5, 0, 0); send(6, 0, 0);
    clr = 1'b1; @(posedge CLK); #1; clr = 1'b0;
    send(9, 1, 0);
    send(20, 0, 0);
    send(4, 1, 1);
    drain("clr");

    // narrow build: positive and negative clamp, count saturation
    expect64(64'sh7FFF_FFFF_FFFF_FFFF, 3, 1);
    expect64(64'sh8000_0000_0000_0005, 3, 1);
    expect64(5, 3, 0);
    send64(64'sh7FFF_FFFF_FFFF_FFFF, 0); send64(64'sh7FFF_FFFF_FFFF_FFFF, 0); send64(1, 1);
    send64(64'sh8000_0000_0000_0000, 0); send64(64'sh8000_0000_0000_0000, 0); send64(5, 1);
    for (int i = 0; i < 5; i++) send64(1, (i == 4));
    drain("narrow");

    // asynchronous reset with queued results and a partial group
    out_ready = 1'b0;
    send(1, 1, 0); send(2, 1, 0); send(3, 0, 0);
    check("pre_reset_valid", 72'(out_valid), 72'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 72'(out_valid), 72'd0);
    check("async_rst_sum", out_sum, 72'd0);
    check("async_rst_count", 72'(out_count), 72'd0);
    check("async_rst_err_drop", 72'(err_drop), 72'd0);
    @(posedge CLK);
    @(negedge CLK); rst_n = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b1;
    expect72(5, 2, 0);
    send(2, 0, 0); send(3, 1, 0);
    drain("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
